// File: rtl/pg1_isa_pkg.sv
// pg1_isa_pkg: opcode and fetch-state enums, instruction field positions and the opcode legality check
package pg1_isa_pkg;
    typedef enum logic [4:0] {
        OP_RTYPE = 5'd0,
        OP_LDR   = 5'd1,
        OP_STR   = 5'd2,
        OP_BEQ   = 5'd3,
        OP_ADDI  = 5'd4,
        OP_BEQ2  = 5'd5
    } opcode_e;
    typedef enum logic [1:0] {BOOT, RUN, FLUSH} fetch_state_e;
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int ALUOP_MSB = 26;
    localparam int ALUOP_LSB = 24;
    function automatic logic is_legal_op(input logic [4:0] op);
        return op inside {OP_RTYPE, OP_LDR, OP_STR, OP_BEQ, OP_ADDI, OP_BEQ2};
    endfunction
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry FIFO with synchronous flush; head reads as zero when empty
// Ports: clk, rst (sync, active-high), flush (drop all entries), push/din (write),
//        pop (consume head), dout (head entry), valid (non-empty), count (entries held)
module fetch_fifo #(
    parameter int W = 48,
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          valid,
    output logic [CW-1:0] count
);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    logic [W-1:0] mem [DEPTH];
    logic [PW-1:0] rd, wr;
    assign valid = count != '0;
    assign dout = valid ? mem[rd] : '0;
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd <= '0;
            wr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wr] <= din;
                wr <= wr == LAST ? '0 : wr + 1'b1;
            end
            if (pop)
                rd <= rd == LAST ? '0 : rd + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetches instruction words from memory and presents them with opcode fields to decode
// Ports: clk, rst (sync, active-high); imem_req_valid/ready + imem_addr (fetch request);
//        imem_rsp_valid/data (in-order response); dec_valid/ready, OPCODE, ALUOP, dec_instr,
//        dec_pc, dec_illegal (decode side); redirect/redirect_pc (taken branch from execute)
module instr_fetch_unit
    import pg1_isa_pkg::*;
#(
    parameter int AW = 16,
    parameter int DW = 32,
    parameter int DEPTH = 2,
    parameter logic [AW-1:0] RESET_PC = '0,
    parameter int PC_INC = 4
) (
    input  logic          clk,
    input  logic          rst,
    output logic          imem_req_valid,
    input  logic          imem_req_ready,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_rsp_valid,
    input  logic [DW-1:0] imem_rsp_data,
    output logic          dec_valid,
    input  logic          dec_ready,
    output logic [4:0]    OPCODE,
    output logic [2:0]    ALUOP,
    output logic [DW-1:0] dec_instr,
    output logic [AW-1:0] dec_pc,
    output logic          dec_illegal,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int CW1 = CW + 1;
    localparam logic [CW:0] LIMIT = CW1'(DEPTH);
    fetch_state_e state;
    logic [AW-1:0] pc, rsp_pc;
    logic [CW-1:0] outstanding, drop_cnt, drop_next, count;
    logic [AW+DW-1:0] head;
    logic pop, push, accept;
    assign pop = dec_valid && dec_ready;
    assign push = imem_rsp_valid && !redirect && drop_cnt == '0;
    // a head leaving this cycle frees its slot now, which keeps 1 fetch per cycle with a 2-entry buffer
    assign imem_req_valid = state == RUN && !redirect &&
                            ({1'b0, outstanding} + {1'b0, count} - CW1'(pop)) < LIMIT;
    assign accept = imem_req_valid && imem_req_ready;
    assign imem_addr = pc;
    // on redirect every in-flight word is stale; one arriving right now is discarded directly
    assign drop_next = redirect ? outstanding - CW'(imem_rsp_valid)
                                : drop_cnt - CW'(imem_rsp_valid && drop_cnt != '0);
    assign {dec_pc, dec_instr} = head;
    assign OPCODE = dec_instr[OPC_MSB:OPC_LSB];
    assign ALUOP = dec_instr[ALUOP_MSB:ALUOP_LSB];
    assign dec_illegal = !is_legal_op(OPCODE);
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BOOT;
            pc <= RESET_PC;
            rsp_pc <= RESET_PC;
            outstanding <= '0;
            drop_cnt <= '0;
        end else begin
            state <= state == BOOT ? RUN : drop_next != '0 ? FLUSH : RUN;
            pc <= redirect ? redirect_pc : accept ? pc + AW'(PC_INC) : pc;
            // kept words are contiguous from the last redirect target, so their address is a running count
            rsp_pc <= redirect ? redirect_pc : push ? rsp_pc + AW'(PC_INC) : rsp_pc;
            outstanding <= outstanding + CW'(accept) - CW'(imem_rsp_valid);
            drop_cnt <= drop_next;
        end
    end
    fetch_fifo #(.W(AW + DW), .DEPTH(DEPTH)) u_fifo (
        .clk(clk),
        .rst(rst),
        .flush(redirect),
        .push(push),
        .pop(pop),
        .din({rsp_pc, imem_rsp_data}),
        .dout(head),
        .valid(dec_valid),
        .count(count)
    );
endmodule
